full_adder_pipe: RTL and testbench
==================================

# full_adder_pipe

Parameterised ripple-carry adder built from single-bit full-adder cells, with a registered output stage. It adds two WIDTH-bit operands and a carry-in, producing a WIDTH-bit sum and a carry-out. It is the arithmetic leaf used by datapath blocks. With WIDTH=1 it is the classic 1-bit full adder: inputs x, y and carry-in; outputs sum and carry-out.

## Interface
One clock; reset is asynchronous and active-low.

Parameters:
- WIDTH, default 1: operand and sum width in bits; legal range 1..64.
- REGISTERED, default 1: 1 selects registered outputs. 0 selects purely combinational outputs; i_clk, i_rst_n and i_valid are then ignored, and o_valid is tied to 1.

Ports:
- i_clk  input  1  clock, rising-edge active
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  operands valid this cycle
- i_x  input  WIDTH  operand X, unsigned
- i_y  input  WIDTH  operand Y, unsigned
- i_carry  input  1  carry-in
- o_sum  output  WIDTH  sum bits
- o_carry  output  1  carry-out from bit WIDTH-1
- o_valid  output  1  o_sum and o_carry hold a valid result

## Operation
- Bit cell, for each bit i:
  - s_i = x_i ^ y_i ^ c_i
  - c_(i+1) = (x_i & y_i) | (c_i & (x_i ^ y_i))
  - c_0 = i_carry
- Result: {o_carry, o_sum} = i_x + i_y + i_carry, computed exactly at WIDTH+1 bits. There is no truncation and no signed interpretation.
- Maximum value: all-ones + all-ones + 1 gives o_sum = all-ones and o_carry = 1.
- REGISTERED=1:
  - When i_valid=1 at a rising edge, the computed sum and carry are captured and o_valid is set to 1.
  - When i_valid=0, o_sum and o_carry hold their last values and o_valid is cleared to 0.
- REGISTERED=0: outputs follow the inputs combinationally, with no state.
- X/Z on the inputs propagates; no sanitising is performed.

## Timing
- Reset:
  - Assertion of i_rst_n=0 immediately forces o_sum=0, o_carry=0 and o_valid=0, independent of i_clk.
  - Outputs remain cleared while reset is held.
  - The first capture occurs on the first rising edge after deassertion at which i_valid=1.
- Latency, REGISTERED=1: exactly 1 cycle, from the edge sampling i_valid=1 to updated outputs after that same edge. Throughput is one result per cycle.
- Latency, REGISTERED=0: zero cycles (combinational). The critical path is the WIDTH-stage carry chain.
- Back-to-back i_valid: every cycle produces a new result, with no bubbles.
- Reset asserted mid-operation: the in-flight result is discarded and the outputs clear asynchronously.

## Structure
- Sub-module full_adder_bit: ports i_x, i_y, i_carry, o_sum, o_carry, all 1 bit, purely combinational. It is instantiated WIDTH times through a generate loop to form the carry chain.
- Top level contains the chain wiring plus the output register and o_valid flop.
- A shared package, adder_pkg, holds:
  - the WIDTH legality limits, ADDER_MAX_WIDTH = 64;
  - the default latency constant, ADDER_LATENCY = 1, for use by the instantiating datapaths.
- Elaboration check: WIDTH < 1 or WIDTH > ADDER_MAX_WIDTH is a fatal error.

## Test plan
- WIDTH=1, REGISTERED=0, exhaustive sweep of (x,y,c) from 000 to 111, 20 ns per step. Required {o_carry,o_sum}, in order: 00, 01, 01, 10, 01, 10, 10, 11.
- WIDTH=1, REGISTERED=1, same sweep with i_valid=1. Each result appears one cycle after its inputs are sampled, and o_valid=1 from the first capture onward.
- WIDTH=8: x=0xFF, y=0x00, c=1 -> sum=0x00, carry=1. Then x=0xFF, y=0xFF, c=1 -> sum=0xFF, carry=1.
- WIDTH=8: x=0x5A, y=0x25, c=0 -> sum=0x7F, carry=0. Drop i_valid for 3 cycles -> outputs hold 0x7F/0 and o_valid=0.
- Reset: drive a valid result, then pull i_rst_n low between clock edges -> o_sum=0, o_carry=0, o_valid=0 immediately. After release, the first valid input reappears one cycle later.
- WIDTH=16, 1000 random operand/carry vectors, checked against a behavioural (WIDTH+1)-bit reference sum.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the ripple-carry adder family.
package adder_pkg;

    // Legal operand width range for full_adder_pipe.
    localparam int ADDER_MIN_WIDTH = 1;
    localparam int ADDER_MAX_WIDTH = 64;

    // Cycles from an accepted operand to its result when outputs are registered.
    localparam int ADDER_LATENCY = 1;

    // True when a requested operand width can be built.
    function automatic bit adder_width_ok(input int width);
        return (width >= ADDER_MIN_WIDTH) && (width <= ADDER_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full-adder cell: one link of the ripple-carry chain.
module full_adder_bit (
    input  logic i_x,
    input  logic i_y,
    input  logic i_carry,
    output logic o_sum,
    output logic o_carry
);

    logic half_sum;

    // Propagate term is shared by the sum and the carry.
    always_comb begin
        half_sum = i_x ^ i_y;
        o_sum    = half_sum ^ i_carry;
        o_carry  = (i_x & i_y) | (i_carry & half_sum);
    end

endmodule

// File: rtl/full_adder_pipe.sv
// Parameterised ripple-carry adder with an optional registered output stage.
// {o_carry, o_sum} = i_x + i_y + i_carry, exact at WIDTH+1 bits, unsigned.
module full_adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_carry,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_valid
);

    // An unbuildable width stops elaboration instead of producing a broken chain.
    if (!adder_width_ok(WIDTH)) begin : g_width_check
        $fatal(1, "full_adder_pipe: WIDTH=%0d outside 1..%0d", WIDTH, ADDER_MAX_WIDTH);
    end

    // carry_chain[i] is the carry into bit i; carry_chain[WIDTH] is the carry-out.
    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] sum_comb;

    assign carry_chain[0] = i_carry;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_bit u_bit (
            .i_x     (i_x[i]),
            .i_y     (i_y[i]),
            .i_carry (carry_chain[i]),
            .o_sum   (sum_comb[i]),
            .o_carry (carry_chain[i+1])
        );
    end

    // ---- stage p0: output register ----
    if (REGISTERED) begin : g_registered
        logic [WIDTH-1:0] sum_p0;
        logic             carry_p0;
        logic             vld_p0;

        // Capture on valid, hold otherwise; reset clears everything at once.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sum_p0   <= '0;
                carry_p0 <= 1'b0;
                vld_p0   <= 1'b0;
            end else begin
                vld_p0 <= i_valid;
                if (i_valid) begin
                    sum_p0   <= sum_comb;
                    carry_p0 <= carry_chain[WIDTH];
                end
            end
        end

        assign o_sum   = sum_p0;
        assign o_carry = carry_p0;
        assign o_valid = vld_p0;
    end else begin : g_combinational
        // Clock, reset and valid have no role without the register stage.
        logic unused_ctrl;
        assign unused_ctrl = ^{i_clk, i_rst_n, i_valid};

        assign o_sum   = sum_comb;
        assign o_carry = carry_chain[WIDTH];
        assign o_valid = 1'b1;
    end

endmodule

// File: tb/tb_full_adder_pipe.sv
// Directed and random checks of full_adder_pipe in four configurations.
module tb_full_adder_pipe;
    import adder_pkg::*;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_errors;

    // WIDTH=1 combinational
    logic       a_valid, a_x, a_y, a_c;
    logic       a_sum, a_carry, a_vout;
    // WIDTH=1 registered
    logic       b_valid, b_x, b_y, b_c;
    logic       b_sum, b_carry, b_vout;
    // WIDTH=8 registered
    logic       e_valid, e_c;
    logic [7:0] e_x, e_y, e_sum;
    logic       e_carry, e_vout;
    // WIDTH=16 registered
    logic        r_valid, r_c;
    logic [15:0] r_x, r_y, r_sum;
    logic        r_carry, r_vout;

    full_adder_pipe #(.WIDTH(1), .REGISTERED(1'b0)) u_comb1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid),
        .i_x(a_x), .i_y(a_y), .i_carry(a_c),
        .o_sum(a_sum), .o_carry(a_carry), .o_valid(a_vout)
    );

    full_adder_pipe #(.WIDTH(1), .REGISTERED(1'b1)) u_reg1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid),
        .i_x(b_x), .i_y(b_y), .i_carry(b_c),
        .o_sum(b_sum), .o_carry(b_carry), .o_valid(b_vout)
    );

    full_adder_pipe #(.WIDTH(8), .REGISTERED(1'b1)) u_reg8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(e_valid),
        .i_x(e_x), .i_y(e_y), .i_carry(e_c),
        .o_sum(e_sum), .o_carry(e_carry), .o_valid(e_vout)
    );

    full_adder_pipe #(.WIDTH(16), .REGISTERED(1'b1)) u_reg16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(r_valid),
        .i_x(r_x), .i_y(r_y), .i_carry(r_c),
        .o_sum(r_sum), .o_carry(r_carry), .o_valid(r_vout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs driven on the falling edge, outputs read just after the next rising edge.
    task automatic step8(input logic v, input logic [7:0] x, input logic [7:0] y, input logic c);
        @(negedge clk);
        e_valid = v; e_x = x; e_y = y; e_c = c;
        repeat (ADDER_LATENCY) @(posedge clk);
        #1;
    endtask

    logic [1:0]  exp_tbl [8];
    logic [2:0]  k;
    logic [16:0] ref16;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        rst_n   = 1'b0;
        a_valid = 1'b0; a_x = 1'b0; a_y = 1'b0; a_c = 1'b0;
        b_valid = 1'b0; b_x = 1'b0; b_y = 1'b0; b_c = 1'b0;
        e_valid = 1'b0; e_x = 8'h00; e_y = 8'h00; e_c = 1'b0;
        r_valid = 1'b0; r_x = 16'h0; r_y = 16'h0; r_c = 1'b0;

        // Reset state
        #1;
        check("rst_w1_out",  {b_vout, b_carry, b_sum}, 64'h0);
        check("rst_w8_out",  {e_vout, e_carry, e_sum}, 64'h0);
        check("rst_w16_out", {r_vout, r_carry, r_sum}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 combinational exhaustive sweep, 20 ns per step
        for (int i = 0; i < 8; i++) begin
            k = 3'(i);
            a_x = k[2]; a_y = k[1]; a_c = k[0];
            #10;
            check($sformatf("comb_w1_%0d", i), {a_carry, a_sum}, exp_tbl[i]);
            check($sformatf("comb_w1_vld_%0d", i), a_vout, 1'b1);
            #10;
        end

        // WIDTH=1 registered sweep, back-to-back valid
        for (int i = 0; i < 8; i++) begin
            k = 3'(i);
            @(negedge clk);
            b_valid = 1'b1; b_x = k[2]; b_y = k[1]; b_c = k[0];
            @(posedge clk);
            #1;
            check($sformatf("reg_w1_%0d", i), {b_carry, b_sum}, exp_tbl[i]);
            check($sformatf("reg_w1_vld_%0d", i), b_vout, 1'b1);
        end
        @(negedge clk);
        b_valid = 1'b0;

        // WIDTH=8 boundary and hold behaviour
        step8(1'b1, 8'hFF, 8'h00, 1'b1);
        check("w8_ff_00_1", {e_vout, e_carry, e_sum}, {1'b1, 1'b1, 8'h00});
        step8(1'b1, 8'hFF, 8'hFF, 1'b1);
        check("w8_ff_ff_1", {e_vout, e_carry, e_sum}, {1'b1, 1'b1, 8'hFF});
        step8(1'b1, 8'h5A, 8'h25, 1'b0);
        check("w8_5a_25_0", {e_vout, e_carry, e_sum}, {1'b1, 1'b0, 8'h7F});
        for (int i = 0; i < 3; i++) begin
            step8(1'b0, 8'hC3, 8'hA7, 1'b1);
            check($sformatf("w8_hold_%0d", i), {e_vout, e_carry, e_sum}, {1'b0, 1'b0, 8'h7F});
        end

        // Asynchronous reset between edges
        step8(1'b1, 8'h12, 8'h34, 1'b0);
        check("w8_pre_rst", {e_vout, e_carry, e_sum}, {1'b1, 1'b0, 8'h46});
        e_x = 8'h80; e_y = 8'h80; e_c = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("w8_rst_async", {e_vout, e_carry, e_sum}, 64'h0);
        @(posedge clk);
        #1;
        check("w8_rst_held", {e_vout, e_carry, e_sum}, 64'h0);
        @(negedge clk);
        e_valid = 1'b1; e_x = 8'h01; e_y = 8'h02; e_c = 1'b1;
        rst_n = 1'b1;
        #1;
        check("w8_rst_release", {e_vout, e_carry, e_sum}, 64'h0);
        @(posedge clk);
        #1;
        check("w8_first_after_rst", {e_vout, e_carry, e_sum}, {1'b1, 1'b0, 8'h04});
        @(negedge clk);
        e_valid = 1'b0;

        // WIDTH=16 random vectors against a 17-bit reference
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            r_valid = 1'b1;
            r_x = 16'($urandom);
            r_y = 16'($urandom);
            r_c = 1'($urandom);
            ref16 = {1'b0, r_x} + {1'b0, r_y} + {16'h0, r_c};
            @(posedge clk);
            #1;
            check($sformatf("w16_rand_%0d", i), {r_vout, r_carry, r_sum}, {1'b1, ref16});
        end
        @(negedge clk);
        r_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
